// File: rtl/hdc_pkg.sv
// -----------------------------------------------------------------------------
// hdc_pkg
// Shared types for the bundling datapath (slicer, bundler, output collector).
//   bundle_state_t : sequencing state; the slicer/bundler run while S_BUNDLE
//   beats()        : number of PAR_BITS-wide chunks per DIMENSIONS-bit HV
// -----------------------------------------------------------------------------
package hdc_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUNDLE = 2'd1,
      S_DONE   = 2'd2
   } bundle_state_t;

   // Ceiling division: the last chunk may be only partially used.
   function automatic int beats(input int dims, input int par);
      return (dims + par - 1) / par;
   endfunction

endpackage

// File: rtl/bundler_out_collector_chunk_popcount.sv
// -----------------------------------------------------------------------------
// chunk_popcount
// Counts the set bits among the lowest `limit` bits of one bundler chunk.
// Bits at or above `limit` fall outside the HV and are not counted.
// Ports:
//   bits   in  PAR_BITS              chunk from the bundler
//   limit  in  $clog2(PAR_BITS+1)    number of in-range bits (0..PAR_BITS)
//   count  out $clog2(PAR_BITS+1)    popcount of the in-range bits
// -----------------------------------------------------------------------------
module chunk_popcount #(
   parameter int PAR_BITS = 10
) (
   input  logic [PAR_BITS-1:0]             bits,
   input  logic [$clog2(PAR_BITS+1)-1:0]   limit,
   output logic [$clog2(PAR_BITS+1)-1:0]   count
);

   localparam int CW = $clog2(PAR_BITS + 1);

   always_comb begin
      count = '0;
      for (int k = 0; k < PAR_BITS; k++) begin
         if (CW'(k) < limit) begin
            count = count + CW'(bits[k]);
         end
      end
   end

endmodule

// File: rtl/bundler_out_collector.sv
// -----------------------------------------------------------------------------
// bundler_out_collector
// Sink end of the bundling datapath. Sequences the bit offset d that drives
// the bundler input slicer, reassembles PAR_BITS-wide majority-vote chunks
// into one DIMENSIONS-bit HV and hands it downstream with valid/ready.
//
// Optional feature macro: BUNDLER_OUT_DENSITY_EN adds the density port, a
// running popcount of the written HV bits.
//
// Ports:
//   clk         in   clock, all state on rising edge
//   rst         in   asynchronous, active-high reset
//   start       in   begin a new HV (only honoured in S_IDLE)
//   state       out  sequencing state (1 = bundling)
//   d           out  bit offset of the next expected chunk
//   bits_valid  in   chunk valid from the bundler
//   bits_ready  out  chunk accepted (state == S_BUNDLE)
//   bits_in     in   chunk for hv_out[d +: PAR_BITS]
//   hv_valid    out  assembled HV available
//   hv_ready    in   downstream accepts the HV
//   hv_out      out  assembled HV
//   density     out  popcount of hv_out (BUNDLER_OUT_DENSITY_EN only)
// -----------------------------------------------------------------------------
module bundler_out_collector
   import hdc_pkg::*;
#(
   parameter int DIMENSIONS = 10000,
   parameter int PAR_BITS   = 10
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   output logic [1:0]                      state,
   output logic [$clog2(DIMENSIONS)-1:0]   d,
   input  logic                            bits_valid,
   output logic                            bits_ready,
   input  logic [PAR_BITS-1:0]             bits_in,
   output logic                            hv_valid,
   input  logic                            hv_ready,
   output logic [DIMENSIONS-1:0]           hv_out
`ifdef BUNDLER_OUT_DENSITY_EN
   ,
   output logic [$clog2(DIMENSIONS+1)-1:0] density
`endif
);

   localparam int DW = $clog2(DIMENSIONS);

   // Offset arithmetic runs one bit wider than d so d+PAR_BITS cannot wrap
   // before it is compared against DIMENSIONS.
   localparam logic [DW:0] DIM_X = (DW+1)'(DIMENSIONS);
   localparam logic [DW:0] PAR_X = (DW+1)'(PAR_BITS);

   bundle_state_t          cur_state;
   bundle_state_t          nxt_state;
   logic                   load_start;
   logic                   beat;
   logic                   last_beat;
   logic [DW:0]            d_x;
   logic [DW:0]            d_sum;
   logic [DW:0]            idx;
   logic [DW-1:0]          d_next;
   logic [DIMENSIONS-1:0]  wr_mask;
   logic [DIMENSIONS-1:0]  wr_data;

   assign state      = cur_state;
   assign bits_ready = (cur_state == S_BUNDLE);

   assign d_x       = {1'b0, d};
   assign d_sum     = d_x + PAR_X;
   assign last_beat = (d_sum >= DIM_X);
   assign d_next    = last_beat ? '0 : d_sum[DW-1:0];

   // Next-state and control decode.
   always_comb begin
      nxt_state  = cur_state;
      load_start = 1'b0;
      beat       = 1'b0;
      case (cur_state)
         S_IDLE: begin
            if (start) begin
               load_start = 1'b1;
               nxt_state  = S_BUNDLE;
            end
         end
         S_BUNDLE: begin
            beat = bits_valid & bits_ready;
            if (beat && last_beat) begin
               nxt_state = S_DONE;
            end
         end
         S_DONE: begin
            // start is ignored here; only the handshake moves us on
            if (hv_ready) begin
               nxt_state = S_IDLE;
            end
         end
         default: nxt_state = S_IDLE;  // encoding 2'd3 recovers
      endcase
   end

   // hv_valid is a flop so it is glitch-free and rises the cycle after the
   // final beat, together with the S_DONE state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= S_IDLE;
         hv_valid  <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         hv_valid  <= (nxt_state == S_DONE);
      end
   end

   // Scatter the chunk into its HV lanes; lanes past DIMENSIONS are dropped
   // so a truncated final chunk never writes out of range.
   always_comb begin
      wr_mask = '0;
      wr_data = '0;
      idx     = '0;
      for (int k = 0; k < PAR_BITS; k++) begin
         idx = d_x + (DW+1)'(k);
         if (idx < DIM_X) begin
            wr_mask[idx[DW-1:0]] = 1'b1;
            wr_data[idx[DW-1:0]] = bits_in[k];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d      <= '0;
         hv_out <= '0;
      end else if (load_start) begin
         d      <= '0;
         hv_out <= '0;
      end else if (beat) begin
         d      <= d_next;
         hv_out <= (hv_out & ~wr_mask) | wr_data;
      end
   end

`ifdef BUNDLER_OUT_DENSITY_EN
   localparam int CW = $clog2(PAR_BITS + 1);
   localparam int NW = $clog2(DIMENSIONS + 1);

   logic [DW:0]   remaining;
   logic [CW-1:0] limit;
   logic [CW-1:0] chunk_cnt;

   // Only the in-range part of the final chunk contributes to the count.
   assign remaining = DIM_X - d_x;
   assign limit     = (remaining >= PAR_X) ? CW'(PAR_BITS) : CW'(remaining);

   chunk_popcount #(
      .PAR_BITS (PAR_BITS)
   ) u_chunk_popcount (
      .bits  (bits_in),
      .limit (limit),
      .count (chunk_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         density <= '0;
      end else if (load_start) begin
         density <= '0;
      end else if (beat) begin
         density <= density + NW'(chunk_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_bundler_out_collector.sv
// -----------------------------------------------------------------------------
// tb_bundler_out_collector
// Bench for bundler_out_collector with two instances: D=40/P=10 (exact fit)
// and D=25/P=10 (truncated final chunk). Expected HVs come from a chunk-position
// model: chunk c bit k lands at HV bit c*P+k when that position exists.
// Density checks are compiled in when BUNDLER_OUT_DENSITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_bundler_out_collector;

   typedef logic [9:0] chunks_t [4];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        a_start, a_bv, a_hr, a_br, a_hv;
   logic [9:0]  a_bits;
   logic [1:0]  a_state;
   logic [5:0]  a_d;
   logic [39:0] a_hvout;

   logic        b_start, b_bv, b_hr, b_br, b_hv;
   logic [9:0]  b_bits;
   logic [1:0]  b_state;
   logic [4:0]  b_d;
   logic [24:0] b_hvout;

`ifdef BUNDLER_OUT_DENSITY_EN
   logic [5:0]  a_den;
   logic [4:0]  b_den;
`endif

   int errors = 0;
   int checks = 0;

   bundler_out_collector #(.DIMENSIONS(40), .PAR_BITS(10)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .state(a_state), .d(a_d),
      .bits_valid(a_bv), .bits_ready(a_br), .bits_in(a_bits),
      .hv_valid(a_hv), .hv_ready(a_hr), .hv_out(a_hvout)
`ifdef BUNDLER_OUT_DENSITY_EN
      , .density(a_den)
`endif
   );

   bundler_out_collector #(.DIMENSIONS(25), .PAR_BITS(10)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .state(b_state), .d(b_d),
      .bits_valid(b_bv), .bits_ready(b_br), .bits_in(b_bits),
      .hv_valid(b_hv), .hv_ready(b_hr), .hv_out(b_hvout)
`ifdef BUNDLER_OUT_DENSITY_EN
      , .density(b_den)
`endif
   );

   // Reference: place chunk c at bit offset c*10, discard positions >= dims.
   function automatic logic [63:0] model_hv(input int dims, input chunks_t ch);
      logic [63:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 10; k++)
            if (c * 10 + k < dims) r[c * 10 + k] = ch[c][k];
      return r;
   endfunction

   function automatic chunks_t rand_chunks();
      chunks_t ch;
      for (int c = 0; c < 4; c++) ch[c] = 10'($urandom);
      return ch;
   endfunction

   task automatic start_a();
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
   endtask

   // Drives the four chunks; on return (a negedge) the last beat has been taken.
   task automatic send_a(input chunks_t ch, input bit gaps);
      for (int c = 0; c < 4; c++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk); a_bv = 1'b0; a_bits = 10'($urandom);
            end
         end
         @(negedge clk); a_bv = 1'b1; a_bits = ch[c];
      end
      @(negedge clk); a_bv = 1'b0; a_bits = 10'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      if (a_state !== 2'd0 || a_d !== 6'd0 || a_hvout !== 40'd0 || a_hv !== 1'b0 || a_br !== 1'b0) begin
         errors++;
         $display("FAIL reset_a: state=%0d d=%0d hv_out=%h hv_valid=%b bits_ready=%b, want all 0", a_state, a_d, a_hvout, a_hv, a_br);
      end
      checks++;
      if (b_state !== 2'd0 || b_d !== 5'd0 || b_hvout !== 25'd0 || b_hv !== 1'b0 || b_br !== 1'b0) begin
         errors++;
         $display("FAIL reset_b: state=%0d d=%0d hv_out=%h hv_valid=%b bits_ready=%b, want all 0", b_state, b_d, b_hvout, b_hv, b_br);
      end
      checks++;
`ifdef BUNDLER_OUT_DENSITY_EN
      if (a_den !== 6'd0 || b_den !== 5'd0) begin
         errors++;
         $display("FAIL reset_density: a=%0d b=%0d want 0", a_den, b_den);
      end
      checks++;
`endif
      rst = 1'b0;
   endtask

   task automatic test_basic();
      chunks_t ch;
      logic [63:0] m;
      logic [39:0] exp_hv;
      ch = '{10'h3FF, 10'h000, 10'h155, 10'h2AA};
      m = model_hv(40, ch);
      exp_hv = m[39:0];
      start_a();
      if (a_state !== 2'd1 || a_d !== 6'd0 || a_br !== 1'b1 || a_hv !== 1'b0) begin
         errors++;
         $display("FAIL basic_start: state=%0d d=%0d bits_ready=%b hv_valid=%b want 1/0/1/0", a_state, a_d, a_br, a_hv);
      end
      checks++;
      send_a(ch, 1'b0);
      if (a_hv !== 1'b1 || a_state !== 2'd2 || a_d !== 6'd0 || a_br !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: hv_valid=%b state=%0d d=%0d bits_ready=%b want 1/2/0/0", a_hv, a_state, a_d, a_br);
      end
      checks++;
      if (a_hvout !== exp_hv) begin
         errors++;
         $display("FAIL basic_hv: got %h want %h", a_hvout, exp_hv);
      end
      checks++;
`ifdef BUNDLER_OUT_DENSITY_EN
      if (a_den !== 6'd20) begin
         errors++;
         $display("FAIL basic_density: got %0d want 20", a_den);
      end
      checks++;
`endif
      @(negedge clk); a_hr = 1'b1;
      @(negedge clk); a_hr = 1'b0;
      if (a_state !== 2'd0 || a_hv !== 1'b0 || a_hvout !== exp_hv) begin
         errors++;
         $display("FAIL basic_handshake: state=%0d hv_valid=%b hv_out=%h want 0/0/%h", a_state, a_hv, a_hvout, exp_hv);
      end
      checks++;
   endtask

   task automatic test_truncate();
      @(negedge clk); b_start = 1'b1;
      @(negedge clk); b_start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (b_d !== 5'(c * 10)) begin
            errors++;
            $display("FAIL trunc_d%0d: got %0d want %0d", c, b_d, c * 10);
         end
         checks++;
         b_bv = 1'b1; b_bits = 10'h3FF;
      end
      @(negedge clk); b_bv = 1'b0;
      if (b_d !== 5'd0 || b_hv !== 1'b1 || b_state !== 2'd2 || b_hvout !== 25'h1FFFFFF) begin
         errors++;
         $display("FAIL trunc_done: d=%0d hv_valid=%b state=%0d hv_out=%h want 0/1/2/1ffffff", b_d, b_hv, b_state, b_hvout);
      end
      checks++;
`ifdef BUNDLER_OUT_DENSITY_EN
      if (b_den !== 5'd25) begin
         errors++;
         $display("FAIL trunc_density: got %0d want 25", b_den);
      end
      checks++;
`endif
      @(negedge clk); b_hr = 1'b1;
      @(negedge clk); b_hr = 1'b0;
      if (b_state !== 2'd0 || b_hv !== 1'b0) begin
         errors++;
         $display("FAIL trunc_handshake: state=%0d hv_valid=%b want 0/0", b_state, b_hv);
      end
      checks++;
   endtask

   task automatic test_stall();
      chunks_t ch;
      logic [63:0] m;
      ch = rand_chunks();
      m = model_hv(40, ch);
      start_a();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (a_d !== 6'(c * 10)) begin
            errors++;
            $display("FAIL stall_d%0d: got %0d want %0d", c, a_d, c * 10);
         end
         checks++;
         a_bv = 1'b1; a_bits = ch[c];
         @(negedge clk); a_bv = 1'b0; a_bits = 10'($urandom);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (a_hv !== 1'b1 || a_state !== 2'd2 || a_hvout !== m[39:0]) begin
            errors++;
            $display("FAIL stall_hold%0d: hv_valid=%b state=%0d hv_out=%h want 1/2/%h", i, a_hv, a_state, a_hvout, m[39:0]);
         end
         checks++;
      end
      a_hr = 1'b1;
      @(negedge clk); a_hr = 1'b0;
      if (a_state !== 2'd0 || a_hv !== 1'b0 || a_hvout !== m[39:0]) begin
         errors++;
         $display("FAIL stall_release: state=%0d hv_valid=%b hv_out=%h", a_state, a_hv, a_hvout);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      chunks_t ch;
      logic [63:0] m;
      start_a();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); a_bv = 1'b1; a_bits = 10'h3FF;
      end
      @(negedge clk); a_bv = 1'b0;
      rst = 1'b1;
      #1;
      if (a_state !== 2'd0 || a_d !== 6'd0 || a_hvout !== 40'd0 || a_hv !== 1'b0 || a_br !== 1'b0) begin
         errors++;
         $display("FAIL midreset: state=%0d d=%0d hv_out=%h hv_valid=%b bits_ready=%b want all 0", a_state, a_d, a_hvout, a_hv, a_br);
      end
      checks++;
`ifdef BUNDLER_OUT_DENSITY_EN
      if (a_den !== 6'd0) begin
         errors++;
         $display("FAIL midreset_density: got %0d want 0", a_den);
      end
      checks++;
`endif
      @(negedge clk); rst = 1'b0;
      ch = rand_chunks();
      ch[0] = 10'h000;  // stale ones from before reset would show here
      m = model_hv(40, ch);
      start_a();
      send_a(ch, 1'b1);
      if (a_hv !== 1'b1 || a_hvout !== m[39:0]) begin
         errors++;
         $display("FAIL midreset_fresh: hv_valid=%b hv_out=%h want 1/%h", a_hv, a_hvout, m[39:0]);
      end
      checks++;
      @(negedge clk); a_hr = 1'b1;
      @(negedge clk); a_hr = 1'b0;
   endtask

   task automatic test_start_ignored();
      chunks_t ch;
      logic [63:0] m;
      ch = rand_chunks();
      m = model_hv(40, ch);
      start_a();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (a_d !== 6'(c * 10) || a_state !== 2'd1) begin
            errors++;
            $display("FAIL ign_bundle%0d: d=%0d state=%0d want %0d/1", c, a_d, a_state, c * 10);
         end
         checks++;
         a_start = 1'b1; a_bv = 1'b1; a_bits = ch[c];
      end
      @(negedge clk); a_bv = 1'b0;
      repeat (2) @(negedge clk);
      if (a_state !== 2'd2 || a_hv !== 1'b1 || a_hvout !== m[39:0]) begin
         errors++;
         $display("FAIL ign_done: state=%0d hv_valid=%b hv_out=%h want 2/1/%h", a_state, a_hv, a_hvout, m[39:0]);
      end
      checks++;
      a_hr = 1'b1;
      @(negedge clk); a_hr = 1'b0; a_start = 1'b0;
      if (a_state !== 2'd0 || a_hv !== 1'b0) begin
         errors++;
         $display("FAIL ign_handshake: state=%0d hv_valid=%b want 0/0", a_state, a_hv);
      end
      checks++;
      @(negedge clk);
      if (a_state !== 2'd0) begin
         errors++;
         $display("FAIL ign_noqueue: state=%0d want 0", a_state);
      end
      checks++;
   endtask

   task automatic test_back_to_back();
      chunks_t ch;
      logic [63:0] m;
      start_a();
      for (int n = 0; n < 4; n++) begin
         ch = rand_chunks();
         m = model_hv(40, ch);
         send_a(ch, 1'b1);
         if (a_hv !== 1'b1 || a_hvout !== m[39:0]) begin
            errors++;
            $display("FAIL b2b_hv%0d: hv_valid=%b hv_out=%h want 1/%h", n, a_hv, a_hvout, m[39:0]);
         end
         checks++;
`ifdef BUNDLER_OUT_DENSITY_EN
         if (a_den !== 6'($countones(m[39:0]))) begin
            errors++;
            $display("FAIL b2b_density%0d: got %0d want %0d", n, a_den, $countones(m[39:0]));
         end
         checks++;
`endif
         a_hr = 1'b1;
         @(negedge clk); a_hr = 1'b0; a_start = 1'b1;
         @(negedge clk); a_start = 1'b0;
         if (a_state !== 2'd1 || a_d !== 6'd0 || a_hv !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart%0d: state=%0d d=%0d hv_valid=%b want 1/0/0", n, a_state, a_d, a_hv);
         end
         checks++;
      end
      // leave dut_a idle: finish the open HV and hand it off
      send_a(rand_chunks(), 1'b0);
      a_hr = 1'b1;
      @(negedge clk); a_hr = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a_start = 1'b0; a_bv = 1'b0; a_hr = 1'b0; a_bits = '0;
      b_start = 1'b0; b_bv = 1'b0; b_hr = 1'b0; b_bits = '0;
      test_reset();
      test_basic();
      test_truncate();
      test_stall();
      test_reset_mid();
      test_start_ignored();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
